// File: rtl/fetch_buffer.sv
// Dual-issue instruction queue between imem and decode: circular FIFO that accepts
// up to two fetched instructions per cycle and presents the two oldest to decode.
module fetch_buffer #(
  parameter int unsigned IWIDTH   = 32,
  parameter int unsigned PC_WIDTH = 32,
  parameter int unsigned DEPTH    = 8
) (
  input  logic                     fb_clk,
  input  logic                     fb_rst,
  input  logic                     fb_i_flush,
  input  logic                     fb_i_ce,
  input  logic                     fb_i_valid_2,
  input  logic [PC_WIDTH-1:0]      fb_i_pc,
  input  logic [IWIDTH-1:0]        fb_i_instr_1,
  input  logic [IWIDTH-1:0]        fb_i_instr_2,
  output logic                     fb_o_ready,
  output logic                     fb_o_valid_1,
  output logic                     fb_o_valid_2,
  output logic [IWIDTH-1:0]        fb_o_instr_1,
  output logic [IWIDTH-1:0]        fb_o_instr_2,
  output logic [PC_WIDTH-1:0]      fb_o_pc_1,
  output logic [PC_WIDTH-1:0]      fb_o_pc_2,
  input  logic                     fb_i_deq_1,
  input  logic                     fb_i_deq_2,
  output logic [$clog2(DEPTH):0]   fb_o_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [IWIDTH-1:0]   instr_mem [DEPTH];
  logic [PC_WIDTH-1:0] pc_mem    [DEPTH];

  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW-1:0] rd_ptr_next, wr_ptr_next;
  logic [AW-1:0] rd_ptr_p1, wr_ptr_p1;
  logic [CW-1:0] count, count_next;
  logic          do_enq;
  logic [1:0]    n_enq, n_deq;

  // Status is derived from the registered count only, so ready has no path from deq.
  assign fb_o_ready   = (CW'(DEPTH) - count) >= CW'(2);
  assign fb_o_valid_1 = count != '0;
  assign fb_o_valid_2 = count >= CW'(2);
  assign fb_o_count   = count;

  assign rd_ptr_p1 = rd_ptr + AW'(1);
  assign wr_ptr_p1 = wr_ptr + AW'(1);

  // Show-ahead read of the two oldest entries.
  assign fb_o_instr_1 = instr_mem[rd_ptr];
  assign fb_o_instr_2 = instr_mem[rd_ptr_p1];
  assign fb_o_pc_1    = pc_mem[rd_ptr];
  assign fb_o_pc_2    = pc_mem[rd_ptr_p1];

  // Next-state: flush overrides any same-cycle enqueue or dequeue.
  always_comb begin
    do_enq      = fb_i_ce & fb_o_ready & ~fb_i_flush;
    n_enq       = 2'd0;
    n_deq       = 2'd0;
    rd_ptr_next = rd_ptr;
    wr_ptr_next = wr_ptr;
    count_next  = count;

    if (do_enq) begin
      n_enq = fb_i_valid_2 ? 2'd2 : 2'd1;
    end
    if (fb_i_deq_1 & fb_o_valid_1 & ~fb_i_flush) begin
      n_deq = (fb_i_deq_2 & fb_o_valid_2) ? 2'd2 : 2'd1;
    end

    if (fb_i_flush) begin
      rd_ptr_next = '0;
      wr_ptr_next = '0;
      count_next  = '0;
    end else begin
      rd_ptr_next = rd_ptr + AW'(n_deq);
      wr_ptr_next = wr_ptr + AW'(n_enq);
      count_next  = count + CW'(n_enq) - CW'(n_deq);
    end
  end

  always_ff @(posedge fb_clk or posedge fb_rst) begin
    if (fb_rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_ptr_next;
      wr_ptr <= wr_ptr_next;
      count  <= count_next;
    end
  end

  // Entry storage is not reset; validity is tracked by count alone.
  always_ff @(posedge fb_clk) begin
    if (do_enq) begin
      instr_mem[wr_ptr] <= fb_i_instr_1;
      pc_mem[wr_ptr]    <= fb_i_pc;
      if (fb_i_valid_2) begin
        instr_mem[wr_ptr_p1] <= fb_i_instr_2;
        pc_mem[wr_ptr_p1]    <= fb_i_pc + PC_WIDTH'(4);
      end
    end
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// Self-checking bench for fetch_buffer: queue scoreboard of expected {pc, instr}
// entries, compared against the show-ahead outputs as decode consumes them.
module tb_fetch_buffer;

  logic        fb_clk = 1'b0;
  logic        fb_rst = 1'b1;
  logic        fb_i_flush = 1'b0;
  logic        fb_i_ce = 1'b0;
  logic        fb_i_valid_2 = 1'b0;
  logic [31:0] fb_i_pc = '0;
  logic [31:0] fb_i_instr_1 = '0;
  logic [31:0] fb_i_instr_2 = '0;
  logic        fb_o_ready;
  logic        fb_o_valid_1;
  logic        fb_o_valid_2;
  logic [31:0] fb_o_instr_1;
  logic [31:0] fb_o_instr_2;
  logic [31:0] fb_o_pc_1;
  logic [31:0] fb_o_pc_2;
  logic        fb_i_deq_1 = 1'b0;
  logic        fb_i_deq_2 = 1'b0;
  logic [3:0]  fb_o_count;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t sb[$];
  int   tests_run = 0;
  int   tests_failed = 0;

  fetch_buffer #(.IWIDTH(32), .PC_WIDTH(32), .DEPTH(8)) dut (
    .fb_clk(fb_clk), .fb_rst(fb_rst), .fb_i_flush(fb_i_flush), .fb_i_ce(fb_i_ce),
    .fb_i_valid_2(fb_i_valid_2), .fb_i_pc(fb_i_pc), .fb_i_instr_1(fb_i_instr_1),
    .fb_i_instr_2(fb_i_instr_2), .fb_o_ready(fb_o_ready), .fb_o_valid_1(fb_o_valid_1),
    .fb_o_valid_2(fb_o_valid_2), .fb_o_instr_1(fb_o_instr_1), .fb_o_instr_2(fb_o_instr_2),
    .fb_o_pc_1(fb_o_pc_1), .fb_o_pc_2(fb_o_pc_2), .fb_i_deq_1(fb_i_deq_1),
    .fb_i_deq_2(fb_i_deq_2), .fb_o_count(fb_o_count)
  );

  always #5 fb_clk = ~fb_clk;

  // Drive one cycle of stimulus, advance past the edge and update the scoreboard.
  task automatic step(input logic ce, input logic v2, input logic [31:0] pc,
                      input logic [31:0] i1, input logic [31:0] i2,
                      input logic d1, input logic d2, input logic fl);
    int nd;
    bit rdy;
    fb_i_ce = ce; fb_i_valid_2 = v2; fb_i_pc = pc; fb_i_instr_1 = i1; fb_i_instr_2 = i2;
    fb_i_deq_1 = d1; fb_i_deq_2 = d2; fb_i_flush = fl;
    rdy = (8 - sb.size()) >= 2;
    @(posedge fb_clk);
    #1;
    if (fl) begin
      sb.delete();
    end else begin
      nd = 0;
      if (d1 && sb.size() >= 1) nd = (d2 && sb.size() >= 2) ? 2 : 1;
      for (int k = 0; k < nd; k++) void'(sb.pop_front());
      if (ce && rdy) begin
        sb.push_back('{pc, i1});
        if (v2) sb.push_back('{pc + 32'd4, i2});
      end
    end
    fb_i_ce = 1'b0; fb_i_valid_2 = 1'b0; fb_i_deq_1 = 1'b0; fb_i_deq_2 = 1'b0; fb_i_flush = 1'b0;
  endtask

  task automatic test_reset();
    fb_rst = 1'b1;
    repeat (2) @(posedge fb_clk);
    #1;
    tests_run++;
    if ({fb_o_count, fb_o_ready, fb_o_valid_1, fb_o_valid_2} !== {4'd0, 1'b1, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_hold: cnt/rdy/v1/v2 got %0d/%b/%b/%b want 0/1/0/0",
               fb_o_count, fb_o_ready, fb_o_valid_1, fb_o_valid_2);
    end
    fb_rst = 1'b0;
    repeat (3) @(posedge fb_clk);
    #1;
    tests_run++;
    if ({fb_o_count, fb_o_ready, fb_o_valid_1, fb_o_valid_2} !== {4'd0, 1'b1, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_idle: cnt/rdy/v1/v2 got %0d/%b/%b/%b want 0/1/0/0",
               fb_o_count, fb_o_ready, fb_o_valid_1, fb_o_valid_2);
    end
  endtask

  task automatic test_single_pair();
    step(1'b1, 1'b1, 32'h0, 32'hA, 32'hB, 1'b0, 1'b0, 1'b0);
    tests_run++;
    if ({fb_o_valid_1, fb_o_valid_2, fb_o_count} !== {1'b1, 1'b1, 4'd2} ||
        fb_o_pc_1 !== 32'h0 || fb_o_pc_2 !== 32'h4 ||
        fb_o_instr_1 !== 32'hA || fb_o_instr_2 !== 32'hB) begin
      tests_failed++;
      $display("FAIL pair: v=%b%b cnt=%0d pc=%h/%h ins=%h/%h want v=11 cnt=2 pc=0/4 ins=A/B",
               fb_o_valid_1, fb_o_valid_2, fb_o_count, fb_o_pc_1, fb_o_pc_2,
               fb_o_instr_1, fb_o_instr_2);
    end
    step(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b1, 1'b0);
    tests_run++;
    if (fb_o_count !== 4'd0 || fb_o_valid_1 !== 1'b0) begin
      tests_failed++;
      $display("FAIL pair_drain: cnt=%0d v1=%b want 0/0", fb_o_count, fb_o_valid_1);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++)
      step(1'b1, 1'b1, 32'h100 + 32'(8 * i), 32'hA + 32'(2 * i), 32'hB + 32'(2 * i),
           1'b0, 1'b0, 1'b0);
    tests_run++;
    if (fb_o_count !== 4'd8 || fb_o_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL fill: cnt=%0d rdy=%b want 8/0", fb_o_count, fb_o_ready);
    end
    step(1'b1, 1'b1, 32'h200, 32'hDEAD, 32'hBEEF, 1'b0, 1'b0, 1'b0);
    tests_run++;
    if (fb_o_count !== 4'd8 || fb_o_pc_1 !== 32'h100 || fb_o_instr_1 !== 32'hA ||
        fb_o_pc_2 !== 32'h104 || fb_o_instr_2 !== 32'hB) begin
      tests_failed++;
      $display("FAIL fill_hold: cnt=%0d pc=%h/%h ins=%h/%h want 8 pc=100/104 ins=A/B",
               fb_o_count, fb_o_pc_1, fb_o_pc_2, fb_o_instr_1, fb_o_instr_2);
    end
  endtask

  task automatic test_back_to_back();
    int guard;
    for (int c = 0; c < 12; c++) begin
      tests_run++;
      if (fb_o_valid_1 !== 1'b1 || fb_o_valid_2 !== 1'b1 ||
          fb_o_pc_1 !== sb[0].pc || fb_o_instr_1 !== sb[0].instr ||
          fb_o_pc_2 !== sb[1].pc || fb_o_instr_2 !== sb[1].instr ||
          fb_o_count !== 4'(sb.size())) begin
        tests_failed++;
        $display("FAIL b2b[%0d]: pc=%h/%h ins=%h/%h cnt=%0d want pc=%h/%h ins=%h/%h cnt=%0d",
                 c, fb_o_pc_1, fb_o_pc_2, fb_o_instr_1, fb_o_instr_2, fb_o_count,
                 sb[0].pc, sb[1].pc, sb[0].instr, sb[1].instr, sb.size());
      end
      step(1'b1, 1'b1, 32'h300 + 32'(8 * c), 32'hC000_0000 + 32'(2 * c),
           32'hC000_0001 + 32'(2 * c), 1'b1, 1'b1, 1'b0);
    end
    guard = 0;
    while (sb.size() > 0 && guard < 20) begin
      guard++;
      tests_run++;
      if (fb_o_valid_1 !== 1'b1 || fb_o_pc_1 !== sb[0].pc || fb_o_instr_1 !== sb[0].instr) begin
        tests_failed++;
        $display("FAIL drain: v1=%b pc=%h ins=%h want 1 pc=%h ins=%h",
                 fb_o_valid_1, fb_o_pc_1, fb_o_instr_1, sb[0].pc, sb[0].instr);
      end
      step(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b0);
    end
    tests_run++;
    if (sb.size() != 0 || fb_o_count !== 4'd0 || fb_o_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL drain_end: cnt=%0d rdy=%b want 0/1", fb_o_count, fb_o_ready);
    end
  endtask

  task automatic test_single_slot();
    step(1'b1, 1'b0, 32'h10, 32'h1111, 32'h2222, 1'b0, 1'b0, 1'b0);
    tests_run++;
    if ({fb_o_count, fb_o_valid_1, fb_o_valid_2} !== {4'd1, 1'b1, 1'b0} ||
        fb_o_pc_1 !== 32'h10 || fb_o_instr_1 !== 32'h1111) begin
      tests_failed++;
      $display("FAIL single: cnt=%0d v=%b%b pc=%h ins=%h want 1 v=10 pc=10 ins=1111",
               fb_o_count, fb_o_valid_1, fb_o_valid_2, fb_o_pc_1, fb_o_instr_1);
    end
    step(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b1, 1'b0);
    tests_run++;
    if (fb_o_count !== 4'd0 || fb_o_valid_1 !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_deq: cnt=%0d v1=%b want 0/0", fb_o_count, fb_o_valid_1);
    end
    step(1'b1, 1'b1, 32'h20, 32'h3333, 32'h4444, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b1, 1'b0);
    tests_run++;
    if (fb_o_count !== 4'd2 || fb_o_pc_1 !== 32'h20 || fb_o_instr_2 !== 32'h4444) begin
      tests_failed++;
      $display("FAIL deq2_only: cnt=%0d pc1=%h ins2=%h want 2 pc1=20 ins2=4444",
               fb_o_count, fb_o_pc_1, fb_o_instr_2);
    end
    step(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_flush();
    step(1'b1, 1'b1, 32'h40, 32'h5, 32'h6, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'h48, 32'h7, 32'h8, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 32'h50, 32'h9, 32'h0, 1'b0, 1'b0, 1'b0);
    tests_run++;
    if (fb_o_count !== 4'd5) begin
      tests_failed++;
      $display("FAIL flush_pre: cnt=%0d want 5", fb_o_count);
    end
    step(1'b1, 1'b1, 32'h60, 32'hE, 32'hF, 1'b1, 1'b0, 1'b1);
    tests_run++;
    if ({fb_o_count, fb_o_valid_1, fb_o_valid_2, fb_o_ready} !== {4'd0, 1'b0, 1'b0, 1'b1}) begin
      tests_failed++;
      $display("FAIL flush: cnt=%0d v=%b%b rdy=%b want 0 v=00 rdy=1",
               fb_o_count, fb_o_valid_1, fb_o_valid_2, fb_o_ready);
    end
  endtask

  task automatic test_pc_wrap();
    step(1'b1, 1'b1, 32'hFFFF_FFFC, 32'h77, 32'h88, 1'b0, 1'b0, 1'b0);
    tests_run++;
    if (fb_o_pc_1 !== 32'hFFFF_FFFC || fb_o_pc_2 !== 32'h0 || fb_o_instr_2 !== 32'h88) begin
      tests_failed++;
      $display("FAIL pc_wrap: pc=%h/%h ins2=%h want fffffffc/00000000 ins2=88",
               fb_o_pc_1, fb_o_pc_2, fb_o_instr_2);
    end
  endtask

  task automatic test_async_reset();
    step(1'b1, 1'b1, 32'h80, 32'h1, 32'h2, 1'b0, 1'b0, 1'b0);
    fb_rst = 1'b1;
    #2;
    sb.delete();
    tests_run++;
    if ({fb_o_count, fb_o_ready, fb_o_valid_1, fb_o_valid_2} !== {4'd0, 1'b1, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL async_rst: cnt/rdy/v1/v2 got %0d/%b/%b/%b want 0/1/0/0",
               fb_o_count, fb_o_ready, fb_o_valid_1, fb_o_valid_2);
    end
    @(posedge fb_clk);
    #1;
    fb_rst = 1'b0;
    step(1'b1, 1'b0, 32'h90, 32'h3, 32'h0, 1'b0, 1'b0, 1'b0);
    tests_run++;
    if (fb_o_count !== 4'd1 || fb_o_pc_1 !== 32'h90 || fb_o_instr_1 !== 32'h3) begin
      tests_failed++;
      $display("FAIL post_rst: cnt=%0d pc=%h ins=%h want 1 pc=90 ins=3",
               fb_o_count, fb_o_pc_1, fb_o_instr_1);
    end
  endtask

  initial begin
    test_reset();
    test_single_pair();
    test_fill();
    test_back_to_back();
    test_single_slot();
    test_flush();
    test_pc_wrap();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
